// File: rtl/vic_pkg.sv
// Shared VIC-II definitions: register offsets, PAL timing and the raster type.
package vic_pkg;

  localparam logic [5:0] REG_CTRL1  = 6'h11;
  localparam logic [5:0] REG_RASTER = 6'h12;
  localparam logic [5:0] REG_IRR    = 6'h19;
  localparam logic [5:0] REG_IMR    = 6'h1A;

  localparam int unsigned PAL_CYCLES_PER_LINE = 63;
  localparam int unsigned PAL_LINES_PER_FRAME = 312;

  typedef logic [8:0] raster_t;

endpackage

// File: rtl/vic_raster_counter_if.sv
// Register bus between the CPU side and the raster counter block.
interface vic_raster_counter_if;

  logic       reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (
    output reg_we,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_we,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/vic_raster_counter.sv
// 6569 raster timing, raster compare and raster interrupt ($D011.7, $D012, $D019, $D01A).
// Optional feature macro: VIC_RASTER_WRITE_TRIGGER_EN -- a compare write that matches the
// current raster line sets the raster interrupt on the write edge, as on real silicon.
module vic_raster_counter
  import vic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_LINE = PAL_CYCLES_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = PAL_LINES_PER_FRAME
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 phi_en,
  vic_raster_counter_if.slave  bus,
  output logic [5:0]           o_cycle,
  output raster_t              o_raster,
  output logic                 o_line_start,
  output logic                 o_frame_start,
  output logic                 irq_n
);

  localparam logic [5:0] CycleLast  = 6'(CYCLES_PER_LINE - 1);
  localparam raster_t    RasterLast = 9'(LINES_PER_FRAME - 1);

  logic [5:0] cycle_q, cycle_d;
  raster_t    raster_q, raster_d;
  raster_t    compare_q, compare_d;
  logic       irr_q, irr_d;
  logic       imr_q, imr_d;
  logic       line_start_q, frame_start_q;
  logic       line_wrap, frame_wrap;
  logic       raster_hit, write_hit;
  logic       wr_ctrl1, wr_raster, wr_irr, wr_imr;
  logic [7:0] rdata;

  assign wr_ctrl1  = bus.reg_we && (bus.reg_addr == REG_CTRL1);
  assign wr_raster = bus.reg_we && (bus.reg_addr == REG_RASTER);
  assign wr_irr    = bus.reg_we && (bus.reg_addr == REG_IRR);
  assign wr_imr    = bus.reg_we && (bus.reg_addr == REG_IMR);

  // Cycle/raster counter next state and the wrap conditions feeding the strobes.
  always_comb begin
    cycle_d    = cycle_q;
    raster_d   = raster_q;
    line_wrap  = phi_en && (cycle_q == CycleLast);
    frame_wrap = line_wrap && (raster_q == RasterLast);
    if (phi_en) begin
      if (line_wrap) begin
        cycle_d  = '0;
        raster_d = frame_wrap ? '0 : raster_q + 9'd1;
      end else begin
        cycle_d = cycle_q + 6'd1;
      end
    end
  end

  // Compare register, interrupt latch and mask next state; a set event beats an acknowledge.
  always_comb begin
    compare_d = compare_q;
    if (wr_ctrl1)  compare_d[8]   = bus.reg_wdata[7];
    if (wr_raster) compare_d[7:0] = bus.reg_wdata;
    // Only a change of raster line can match, so holding a line never re-fires.
    raster_hit = line_wrap && (raster_d == compare_q);
`ifdef VIC_RASTER_WRITE_TRIGGER_EN
    write_hit = (wr_ctrl1 || wr_raster) && (compare_d == raster_q);
`else
    write_hit = 1'b0;
`endif
    irr_d = irr_q;
    if (wr_irr && bus.reg_wdata[0]) irr_d = 1'b0;
    if (raster_hit || write_hit)    irr_d = 1'b1;
    imr_d = wr_imr ? bus.reg_wdata[0] : imr_q;
  end

  // State registers; everything clears asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q       <= '0;
      raster_q      <= '0;
      compare_q     <= '0;
      irr_q         <= 1'b0;
      imr_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      raster_q      <= raster_d;
      compare_q     <= compare_d;
      irr_q         <= irr_d;
      imr_q         <= imr_d;
      line_start_q  <= line_wrap;
      frame_start_q <= frame_wrap;
    end
  end

  // Register read mux; unused bits read back as 1 like the real chip.
  always_comb begin
    case (bus.reg_addr)
      REG_CTRL1:  rdata = {raster_q[8], 7'b0};
      REG_RASTER: rdata = raster_q[7:0];
      REG_IRR:    rdata = {irr_q & imr_q, 6'b111111, irr_q};
      REG_IMR:    rdata = {7'b1111111, imr_q};
      default:    rdata = 8'hFF;
    endcase
  end

  assign bus.reg_rdata  = rdata;
  assign o_cycle        = cycle_q;
  assign o_raster       = raster_q;
  assign o_line_start   = line_start_q;
  assign o_frame_start  = frame_start_q;
  assign irq_n          = ~(irr_q & imr_q);

endmodule

// File: tb/tb_vic_raster_counter.sv
// Directed bench for vic_raster_counter: register vector table plus raster sequences.
module tb_vic_raster_counter;

  logic       clk;
  logic       reset;
  logic       phi_en;
  logic [5:0] o_cycle;
  logic [8:0] o_raster;
  logic       o_line_start;
  logic       o_frame_start;
  logic       irq_n;

  int total;
  int bad;
  int line_pulses;
  int frame_pulses;

  vic_raster_counter_if bus ();

  vic_raster_counter #(
    .CYCLES_PER_LINE(63),
    .LINES_PER_FRAME(312)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .phi_en       (phi_en),
    .bus          (bus.slave),
    .o_cycle      (o_cycle),
    .o_raster     (o_raster),
    .o_line_start (o_line_start),
    .o_frame_start(o_frame_start),
    .irq_n        (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses just after each active edge.
  always @(posedge clk) begin
    #1;
    if (o_line_start)  line_pulses++;
    if (o_frame_start) frame_pulses++;
  end

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic pe);
    phi_en = pe;
    @(posedge clk);
    @(negedge clk);
    phi_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [7:0] data, input logic pe);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    tick(pe);
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [7:0] exp, input string name);
    bus.reg_addr = addr;
    #1;
    check(name, bus.reg_rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int l0;
  int f0;

  initial begin
    total         = 0;
    bad           = 0;
    line_pulses   = 0;
    frame_pulses  = 0;
    reset         = 1'b0;
    phi_en        = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 6'h00;
    bus.reg_wdata = 8'h00;

    vecs[0]  = '{we: 1'b0, addr: 6'h11, wdata: 8'h00, exp: 8'h00};
    vecs[1]  = '{we: 1'b0, addr: 6'h12, wdata: 8'h00, exp: 8'h00};
    vecs[2]  = '{we: 1'b0, addr: 6'h19, wdata: 8'h00, exp: 8'h7E};
    vecs[3]  = '{we: 1'b0, addr: 6'h1A, wdata: 8'h00, exp: 8'hFE};
    vecs[4]  = '{we: 1'b0, addr: 6'h00, wdata: 8'h00, exp: 8'hFF};
    vecs[5]  = '{we: 1'b0, addr: 6'h3F, wdata: 8'h00, exp: 8'hFF};
    vecs[6]  = '{we: 1'b1, addr: 6'h1A, wdata: 8'h01, exp: 8'hFF};
    vecs[7]  = '{we: 1'b1, addr: 6'h1A, wdata: 8'hFE, exp: 8'hFE};
    vecs[8]  = '{we: 1'b1, addr: 6'h12, wdata: 8'h32, exp: 8'h00};
    vecs[9]  = '{we: 1'b1, addr: 6'h11, wdata: 8'hFF, exp: 8'h00};
    vecs[10] = '{we: 1'b1, addr: 6'h19, wdata: 8'hFF, exp: 8'h7E};
    vecs[11] = '{we: 1'b1, addr: 6'h1A, wdata: 8'h03, exp: 8'hFF};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("reset cycle", o_cycle, 0);
    check("reset raster", o_raster, 0);
    check("reset irq_n", irq_n, 1);
    check("reset line_start", o_line_start, 0);
    check("reset frame_start", o_frame_start, 0);

    // Register vectors with counters frozen.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, 1'b0);
      rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d rdata", i));
    end
    check("vec frozen cycle", o_cycle, 0);

    // Counter wrap over a line and a frame.
    do_reset();
    l0 = line_pulses;
    f0 = frame_pulses;
    run(63);
    check("line wrap cycle", o_cycle, 0);
    check("line wrap raster", o_raster, 1);
    check("line_start high", o_line_start, 1);
    check("line pulses 1", line_pulses - l0, 1);
    check("frame pulses 0", frame_pulses - f0, 0);
    tick(1'b0);
    check("line_start one clk", o_line_start, 0);
    run(63 * 311);
    check("frame wrap raster", o_raster, 0);
    check("frame wrap cycle", o_cycle, 0);
    check("frame_start high", o_frame_start, 1);
    check("frame pulses 1", frame_pulses - f0, 1);
    check("line pulses 312", line_pulses - l0, 312);
    tick(1'b0);
    check("frame_start one clk", o_frame_start, 0);

    // Raster IRQ at line 50.
    do_reset();
    wr(6'h12, 8'h32, 1'b0);
    wr(6'h11, 8'h00, 1'b0);
    wr(6'h1A, 8'h01, 1'b0);
    run(50 * 63 - 1);
    check("irq before line 50", irq_n, 1);
    tick(1'b1);
    check("raster at 50", o_raster, 50);
    check("irq at line 50", irq_n, 0);
    rd(6'h19, 8'hFF, "irr pending read");

    // Acknowledge, then no re-trigger until next frame's line 50.
    wr(6'h19, 8'h01, 1'b0);
    check("irq after ack", irq_n, 1);
    rd(6'h19, 8'h7E, "irr acked read");
    run(312 * 63 - 1);
    check("no retrigger in frame", irq_n, 1);
    tick(1'b1);
    check("retrigger next frame", irq_n, 0);

    // Bit 8 compare: line 261, never line 5.
    do_reset();
    wr(6'h11, 8'h80, 1'b0);
    wr(6'h12, 8'h05, 1'b0);
    wr(6'h1A, 8'h01, 1'b0);
    run(6 * 63);
    check("no irq at line 5", irq_n, 1);
    rd(6'h19, 8'h7E, "irr clear past line 5");
    run(261 * 63 - 6 * 63 - 1);
    check("irq before line 261", irq_n, 1);
    tick(1'b1);
    check("raster at 261", o_raster, 261);
    check("irq at line 261", irq_n, 0);

    // Acknowledge on the same edge as a match: set wins.
    wr(6'h19, 8'h01, 1'b0);
    check("ack before collision", irq_n, 1);
    wr(6'h12, 8'h06, 1'b0);
    run(62);
    wr(6'h19, 8'h01, 1'b1);
    check("collision raster", o_raster, 262);
    check("collision irq_n", irq_n, 0);
    rd(6'h19, 8'hFF, "collision irr read");

    // Compare write matching the current line.
    do_reset();
    wr(6'h1A, 8'h01, 1'b0);
    run(100 * 63);
    check("at raster 100", o_raster, 100);
    wr(6'h12, 8'h64, 1'b0);
`ifdef VIC_RASTER_WRITE_TRIGGER_EN
    check("write trigger irq_n", irq_n, 0);
    rd(6'h19, 8'hFF, "write trigger irr");
`else
    check("write trigger irq_n", irq_n, 1);
    rd(6'h19, 8'h7E, "write trigger irr");
`endif

    // Mask off raises irq_n with the latch kept, then reset mid-line.
    wr(6'h1A, 8'h00, 1'b0);
    check("mask off irq_n", irq_n, 1);
    run(62);
    tick(1'b1);
    check("pre-reset line_start", o_line_start, 1);
    check("pre-reset raster", o_raster, 101);
    #2;
    reset = 1'b0;
    #1;
    check("async reset cycle", o_cycle, 0);
    check("async reset raster", o_raster, 0);
    check("async reset line_start", o_line_start, 0);
    check("async reset frame_start", o_frame_start, 0);
    check("async reset irq_n", irq_n, 1);
    rd(6'h1A, 8'hFE, "async reset imr");
    rd(6'h19, 8'h7E, "async reset irr");
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rd(6'h19, 8'h7E, "no event on release");
    check("hold without phi_en", o_cycle, 0);
    tick(1'b1);
    check("count resumes", o_cycle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
